// File: rtl/core_pkg.sv
// Shared core definitions: default datapath width, register-address type and the
// hardwired-zero register address.
package core_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: picks zero / bypassed write data / stored value and
// holds it in the output register with a one-cycle valid flag.
module regfile_rd_port
   import core_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_rd_en,
   input  logic [AW-1:0]       i_rd_addr,
   input  logic [XLEN-1:0]     i_regs [NREGS],
   input  logic [NWR-1:0]      i_wr_en,
   input  logic [NWR*AW-1:0]   i_wr_addr,
   input  logic [NWR*XLEN-1:0] i_wr_data,
   output logic [XLEN-1:0]     o_rd_data,
   output logic                o_rd_valid
);

   logic            w_byp_hit;
   logic [XLEN-1:0] w_byp_data;
   logic [XLEN-1:0] w_rd_val;
   logic [XLEN-1:0] r_rd_data;
   logic            r_rd_valid;

   // Scan ascending so the highest-index matching write port supplies the data.
   always_comb begin
      w_byp_hit  = 1'b0;
      w_byp_data = '0;
      for (int w = 0; w < NWR; w++) begin
         if (i_wr_en[w] && (i_wr_addr[w*AW +: AW] == i_rd_addr)) begin
            w_byp_hit  = 1'b1;
            w_byp_data = i_wr_data[w*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      if ((ZERO_REG != 0) && (i_rd_addr == AW'(ZERO_ADDR)))
         w_rd_val = '0;
      else if ((BYPASS != 0) && w_byp_hit)
         w_rd_val = w_byp_data;
      else
         w_rd_val = i_regs[i_rd_addr];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en)
            r_rd_data <= w_rd_val;
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

endmodule

// File: rtl/regfile_mport.sv
// Multi-port integer register file for the decode stage: NWR writebacks and NRD
// registered operand reads per cycle, optional write bypass and hardwired-zero r0.
module regfile_mport
   import core_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = 32,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NRD-1:0]                rd_en,
   input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
   output logic [NRD*XLEN-1:0]           rd_data,
   output logic [NRD-1:0]                rd_valid,
   input  logic [NWR-1:0]                wr_en,
   input  logic [NWR*$clog2(NREGS)-1:0]  wr_addr,
   input  logic [NWR*XLEN-1:0]           wr_data
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] r_regs [NREGS];

   // Ascending port order: the highest-index write to an address is assigned last and wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++)
            r_regs[i] <= '0;
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == AW'(ZERO_ADDR))))
               r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
         end
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      regfile_rd_port #(
         .XLEN     (XLEN),
         .NREGS    (NREGS),
         .AW       (AW),
         .NWR      (NWR),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_rd_en    (rd_en[p]),
         .i_rd_addr  (rd_addr[p*AW +: AW]),
         .i_regs     (r_regs),
         .i_wr_en    (wr_en),
         .i_wr_addr  (wr_addr),
         .i_wr_data  (wr_data),
         .o_rd_data  (rd_data[p*XLEN +: XLEN]),
         .o_rd_valid (rd_valid[p])
      );
   end

endmodule

// File: tb/tb_regfile_mport.sv
// Bench for regfile_mport: a bypassing and a non-bypassing instance share stimulus;
// a reference model feeds a scoreboard queue checked one cycle after each read.
module tb_regfile_mport;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  rd_en;
   logic [4:0]  ra [2];
   logic [1:0]  wr_en;
   logic [4:0]  wa [2];
   logic [31:0] wd [2];

   logic [9:0]  rd_addr, wr_addr;
   logic [63:0] wr_data;
   logic [63:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_valid_a, rd_valid_b;

   assign rd_addr = {ra[1], ra[0]};
   assign wr_addr = {wa[1], wa[0]};
   assign wr_data = {wd[1], wd[0]};

   always #5 clk = ~clk;

   regfile_mport #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   regfile_mport #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0), .ZERO_REG(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   typedef struct {
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      bit          use_tbl;
      logic [31:0] tbl;
   } sb_t;

   typedef struct {
      logic [1:0]  rd_en;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [1:0]  wr_en;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [31:0] exp0;
   } vec_t;

   sb_t         sb_q [$];
   logic [31:0] mem [32];
   logic [31:0] last_a [2];
   logic [31:0] last_b [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
      logic [31:0] v;
      v = mem[a];
      if (byp) begin
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && wa[w] == a) v = wd[w];
      end
      if (a == 5'd0) v = 32'h0;
      return v;
   endfunction

   // One clock: predict from current inputs, clock, then compare both instances.
   task automatic step(input bit use_tbl, input logic [31:0] tbl);
      bit   exp_v [2];
      sb_t  e;
      if (rst_n) begin
         for (int p = 0; p < 2; p++) begin
            if (rd_en[p]) begin
               e.exp_a   = exp_read(ra[p], 1'b1);
               e.exp_b   = exp_read(ra[p], 1'b0);
               e.use_tbl = use_tbl && (p == 0);
               e.tbl     = tbl;
               sb_q.push_back(e);
            end
         end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem[i] = 32'h0;
         for (int p = 0; p < 2; p++) begin
            last_a[p] = 32'h0;
            last_b[p] = 32'h0;
            exp_v[p]  = 1'b0;
         end
      end else begin
         for (int w = 0; w < 2; w++)
            if (wr_en[w] && wa[w] != 5'd0) mem[wa[w]] = wd[w];
         for (int p = 0; p < 2; p++) exp_v[p] = rd_en[p];
      end
      for (int p = 0; p < 2; p++) begin
         chk($sformatf("valid_a[%0d]", p), {31'h0, rd_valid_a[p]}, {31'h0, exp_v[p]});
         chk($sformatf("valid_b[%0d]", p), {31'h0, rd_valid_b[p]}, {31'h0, exp_v[p]});
         if (exp_v[p] && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            last_a[p] = e.exp_a;
            last_b[p] = e.exp_b;
            if (e.use_tbl) chk("table_port0", rd_data_a[31:0], e.tbl);
         end
         chk($sformatf("data_a[%0d]", p), rd_data_a[p*32 +: 32], last_a[p]);
         chk($sformatf("data_b[%0d]", p), rd_data_b[p*32 +: 32], last_b[p]);
      end
   endtask

   task automatic idle_inputs();
      rd_en = 2'b00; wr_en = 2'b00;
      ra[0] = 5'd0; ra[1] = 5'd0; wa[0] = 5'd0; wa[1] = 5'd0;
      wd[0] = 32'h0; wd[1] = 32'h0;
   endtask

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 32'h0};
      vecs[1]  = '{2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'hDEADBEEF};
      vecs[2]  = '{2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 32'h12, 5'd0, 32'h0, 32'h12};
      vecs[3]  = '{2'b11, 5'd7, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h12};
      vecs[4]  = '{2'b11, 5'd0, 5'd1, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd1, 32'h11, 32'h0};
      vecs[5]  = '{2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0};
      vecs[6]  = '{2'b01, 5'd3, 5'd0, 2'b11, 5'd3, 32'hA, 5'd3, 32'hB, 32'hB};
      vecs[7]  = '{2'b11, 5'd3, 5'd1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'hB};
      vecs[8]  = '{2'b00, 5'd3, 5'd3, 2'b10, 5'd0, 32'h0, 5'd5, 32'h1234, 32'h0};
      vecs[9]  = '{2'b10, 5'd0, 5'd5, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0};
      vecs[10] = '{2'b01, 5'd31, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0};

      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
      for (int p = 0; p < 2; p++) begin last_a[p] = 32'h0; last_b[p] = 32'h0; end

      // Reset, then every register reads zero.
      idle_inputs();
      rst_n = 1'b0;
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      rst_n = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rd_en = 2'b11; ra[0] = 5'(i); ra[1] = 5'(32 - i);
         step(1'b1, 32'h0);
      end
      idle_inputs();
      step(1'b0, 32'h0);

      // Directed vector table.
      for (int i = 0; i < 11; i++) begin
         rd_en = vecs[i].rd_en; ra[0] = vecs[i].ra0; ra[1] = vecs[i].ra1;
         wr_en = vecs[i].wr_en; wa[0] = vecs[i].wa0; wd[0] = vecs[i].wd0;
         wa[1] = vecs[i].wa1; wd[1] = vecs[i].wd1;
         step(vecs[i].rd_en[0], vecs[i].exp0);
      end
      idle_inputs();
      step(1'b0, 32'h0);

      // Reset asserted mid-operation with a read and a write pending.
      rst_n = 1'b0;
      rd_en = 2'b11; ra[0] = 5'd9; ra[1] = 5'd5;
      wr_en = 2'b01; wa[0] = 5'd9; wd[0] = 32'h55;
      step(1'b0, 32'h0);
      rst_n = 1'b1;
      idle_inputs();
      step(1'b0, 32'h0);
      rd_en = 2'b11; ra[0] = 5'd9; ra[1] = 5'd5;
      step(1'b1, 32'h0);
      idle_inputs();
      step(1'b0, 32'h0);

      // Random traffic with idle read ports on arbitrary cycles.
      for (int c = 0; c < 300; c++) begin
         rd_en = 2'($urandom_range(0, 3));
         ra[0] = 5'($urandom_range(0, 7));
         ra[1] = 5'($urandom_range(0, 7));
         wr_en = 2'($urandom_range(0, 3));
         wa[0] = 5'($urandom_range(0, 7));
         wa[1] = 5'($urandom_range(0, 7));
         wd[0] = $urandom;
         wd[1] = $urandom;
         step(1'b0, 32'h0);
      end
      idle_inputs();
      step(1'b0, 32'h0);

      chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
